// File: rtl/aes_decipher_ctrl_pkg.sv
// Shared definitions for the AES inverse-cipher round controller: round counts,
// round type codes (same encoding as the round datapath) and FSM state encoding.
package aes_decipher_ctrl_pkg;

    localparam int AES128_ROUNDS = 10;
    localparam int AES256_ROUNDS = 14;

    typedef enum logic [1:0] {
        RT_INIT  = 2'd0,
        RT_MAIN  = 2'd1,
        RT_FINAL = 2'd2,
        RT_NONE  = 2'd3
    } round_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_MAIN  = 2'd2,
        ST_FINAL = 2'd3
    } dec_state_e;

    function automatic logic [3:0] rounds_for(input logic keylen);
        return keylen ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
    endfunction

endpackage

// File: rtl/aes_dec_round_ctr.sv
// Loadable 4-bit round down-counter; last flags the final MAIN round (ctr==1).
module aes_dec_round_ctr (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] ctr,
    output logic       last
);

    logic [3:0] ctr_reg;

    // Load wins over decrement; the floor at zero keeps the counter from wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctr_reg <= 4'd0;
        end else if (load) begin
            ctr_reg <= load_val;
        end else if (dec && (ctr_reg != 4'd0)) begin
            ctr_reg <= ctr_reg - 4'd1;
        end
    end

    assign ctr  = ctr_reg;
    assign last = (ctr_reg == 4'd1);

endmodule

// File: rtl/aes_decipher_ctrl.sv
// AES inverse-cipher round sequencer: holds the block state, walks key indices
// Nr..0 and feeds the combinational decipher round one round per cycle.
module aes_decipher_ctrl
    import aes_decipher_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic         key_ready,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [1:0]   round_type,
    output logic [127:0] dp_state,
    input  logic [127:0] dp_new_state,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         valid
);

    // Handshake: a block is taken on a rising edge where ready & key_ready & next
    // are all high; valid then stays high until the next block is taken.

    dec_state_e   state, state_nxt;
    logic [127:0] state_reg;
    logic [3:0]   nr_reg;
    logic         valid_reg;
    logic         accept;
    logic         ctr_load;
    logic [3:0]   ctr_load_val;
    logic         ctr_dec;
    logic [3:0]   round_ctr;
    logic         ctr_last;
    round_type_e  rt;

    // The round key only travels from key memory to the datapath.
    logic unused_round_key;
    assign unused_round_key = ^round_key;

    assign accept = (state == ST_IDLE) && next && key_ready;

    aes_dec_round_ctr u_round_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .ctr      (round_ctr),
        .last     (ctr_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_load     = 1'b0;
        ctr_load_val = 4'd0;
        ctr_dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    ctr_load     = 1'b1;
                    ctr_load_val = rounds_for(keylen);
                    state_nxt    = ST_INIT;
                end
            end
            ST_INIT: begin
                ctr_load     = 1'b1;
                ctr_load_val = nr_reg - 4'd1;
                state_nxt    = ST_MAIN;
            end
            ST_MAIN: begin
                if (ctr_last) begin
                    state_nxt = ST_FINAL;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_FINAL: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rt    = RT_NONE;
        round = 4'd0;
        case (state)
            ST_IDLE: begin
                rt    = RT_NONE;
                round = 4'd0;
            end
            ST_INIT: begin
                rt    = RT_INIT;
                round = nr_reg;
            end
            ST_MAIN: begin
                rt    = RT_MAIN;
                round = round_ctr;
            end
            ST_FINAL: begin
                rt    = RT_FINAL;
                round = 4'd0;
            end
            default: begin
                rt    = RT_NONE;
                round = 4'd0;
            end
        endcase
    end

    // Block state and key length are latched at accept so input changes while busy are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= 128'd0;
            nr_reg    <= 4'(AES128_ROUNDS);
            valid_reg <= 1'b0;
        end else if (accept) begin
            state_reg <= block;
            nr_reg    <= rounds_for(keylen);
            valid_reg <= 1'b0;
        end else if (state != ST_IDLE) begin
            state_reg <= dp_new_state;
            if (state == ST_FINAL) begin
                valid_reg <= 1'b1;
            end
        end
    end

    assign round_type = rt;
    assign dp_state   = state_reg;
    assign new_block  = state_reg;
    assign ready      = (state == ST_IDLE);
    assign valid      = valid_reg;

endmodule
